dm_responder: RTL and testbench

- Data-memory responder for the multi-cycle MIPS core: the memory-side end of the controller's load/store request path.
- Accepts one word or byte request at a time from the datapath (driven by the controller's MemWrite/islb/issb decode) and performs the access after a fixed programmable latency.
- Returns read data and a one-cycle acknowledge; the controller holds its memory state (S3/S5) until the acknowledge arrives.

---
 rtl/dm_responder.sv | 128 ++++++++++++
 tb/tb_dm_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: one load/store at a time, completed after LATENCY cycles with a one-cycle ack.
// Optional address checking (out-of-range / unaligned word rejection) is enabled by defining DM_ADDR_CHECK_EN.
module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              we_q;
    logic              byte_q;
    logic              rej_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH];

    logic              reject;
    logic              do_access;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       cur_word;
    logic [7:0]        sel_byte;
    logic [31:0]       merged;

`ifdef DM_ADDR_CHECK_EN
    assign reject = (req_addr[31:ADDR_W+2] != '0) || (!req_byte && (req_addr[1:0] != 2'b00));
`else
    logic unused_addr;
    assign reject      = 1'b0;
    assign unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};
`endif

    assign word_idx  = addr_q[ADDR_W+1:2];
    assign cur_word  = mem[word_idx];
    assign do_access = (state == S_WAIT) && (cnt == 4'd0);

    // Little-endian lane select for loads and lane merge for byte stores.
    always_comb begin
        sel_byte = cur_word[7:0];
        merged   = cur_word;
        case (addr_q[1:0])
            2'd0: begin sel_byte = cur_word[7:0];   merged[7:0]   = wdata_q[7:0]; end
            2'd1: begin sel_byte = cur_word[15:8];  merged[15:8]  = wdata_q[7:0]; end
            2'd2: begin sel_byte = cur_word[23:16]; merged[23:16] = wdata_q[7:0]; end
            default: begin sel_byte = cur_word[31:24]; merged[31:24] = wdata_q[7:0]; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            rej_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        byte_q  <= req_byte;
                        rej_q   <= reject;
                        addr_q  <= req_addr[ADDR_W+1:0];
                        wdata_q <= req_wdata;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= S_DONE;
                        if (rej_q) begin
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end else if (!we_q) begin
                            rdata_q <= byte_q ? {{24{sel_byte[7]}}, sel_byte} : cur_word;
                        end
                    end
                end
                S_DONE: begin
                    err_q <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory has no reset; an asynchronous reset during WAIT leaves state IDLE so no write fires.
    always_ff @(posedge clk) begin
        if (!rst && do_access && we_q && !rej_q) begin
            if (byte_q) mem[word_idx] <= merged;
            else        mem[word_idx] <= wdata_q;
        end
    end

    assign ack   = (state == S_DONE);
    assign busy  = (state != S_IDLE);
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: directed scenarios plus random traffic against a word-array model.
// dut0 uses LATENCY=2/ADDR_W=10, dut1 uses LATENCY=1/ADDR_W=4.
module tb_dm_responder;

    localparam int AW    = 10;
    localparam int DEPTH = 2 ** AW;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid0 = 1'b0;
    logic        req_valid1 = 1'b0;
    logic        req_we = 1'b0;
    logic        req_byte = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        ack0, err0, busy0, ack1, err1, busy1;
    logic [31:0] rdata0, rdata1;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_last;
    logic [32:0] exp_q [$];

    dm_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid0), .req_we(req_we), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    dm_responder #(.ADDR_W(4), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid1), .req_we(req_we), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack1), .rdata(rdata1), .err(err1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: word array indexed modulo depth, lane arithmetic by shifts.
    task automatic model_access(input logic we, input logic byt, input logic [31:0] addr,
                                input logic [31:0] wdata);
        int unsigned idx, lane;
        logic [31:0] b, r;
        logic rej;
        idx  = (addr / 4) % DEPTH;
        lane = addr % 4;
`ifdef DM_ADDR_CHECK_EN
        rej = (addr >= 4 * DEPTH) || (!byt && lane != 0);
`else
        rej = 1'b0;
`endif
        if (rej) begin
            model_last = 32'd0;
            exp_q.push_back({1'b1, 32'd0});
        end else if (we) begin
            if (byt)
                model_mem[idx] = (model_mem[idx] & ~(32'hFF << (8 * lane))) | ((wdata & 32'hFF) << (8 * lane));
            else
                model_mem[idx] = wdata;
            exp_q.push_back({1'b0, model_last});
        end else begin
            b = (model_mem[idx] >> (8 * lane)) & 32'hFF;
            if (byt) r = (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            else     r = model_mem[idx];
            model_last = r;
            exp_q.push_back({1'b0, r});
        end
    endtask

    // One request on dut0: checks idle state, ack latency, busy while waiting, rdata and err.
    task automatic run_req(input string tag, input logic we, input logic byt,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        logic got;
        logic [32:0] e;
        model_access(we, byt, addr, wdata);
        @(negedge clk);
        check({tag, "_idle_busy"}, {31'd0, busy0}, 32'd0);
        check({tag, "_idle_ack"}, {31'd0, ack0}, 32'd0);
        req_valid0 = 1'b1;
        req_we     = we;
        req_byte   = byt;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            got = ack0;
            if (!got) check({tag, "_wait_busy"}, {31'd0, busy0}, 32'd1);
        end
        req_valid0 = 1'b0;
        req_wdata  = $urandom;
        e = exp_q.pop_front();
        check({tag, "_ack_lat"}, n, LAT + 1);
        check({tag, "_rdata"}, rdata0, e[31:0]);
        check({tag, "_err"}, {31'd0, err0}, {31'd0, e[32]});
    endtask

    task automatic run_l1(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_r);
        int n;
        logic got;
        @(negedge clk);
        req_valid1 = 1'b1;
        req_we     = we;
        req_byte   = 1'b0;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            got = ack1;
        end
        req_valid1 = 1'b0;
        check({tag, "_ack_lat"}, n, 2);
        check({tag, "_rdata"}, rdata1, exp_r);
        check({tag, "_err"}, {31'd0, err1}, 32'd0);
    endtask

    initial begin
        int nacks, p;
        logic seen;
        logic [32:0] e;
        logic [31:0] a;

        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        model_last = 32'd0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, ack0}, 32'd0);
        check("rst_err", {31'd0, err0}, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_rdata", rdata0, 32'd0);
        rst = 1'b0;

        // Word store/load and byte lane behaviour
        run_req("t1_sw", 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        run_req("t1_lw", 1'b0, 1'b0, 32'h10, 32'd0);
        check("t1_value", rdata0, 32'hDEAD_BEEF);
        run_req("t2_sb", 1'b1, 1'b1, 32'h12, 32'h1234_565A);
        run_req("t2_lw", 1'b0, 1'b0, 32'h10, 32'd0);
        check("t2_merge", rdata0, 32'hDE5A_BEEF);
        run_req("t2_lb13", 1'b0, 1'b1, 32'h13, 32'd0);
        check("t2_sext", rdata0, 32'hFFFF_FFDE);
        run_req("t2_lb12", 1'b0, 1'b1, 32'h12, 32'd0);
        check("t2_zext", rdata0, 32'h0000_005A);

        // Reset in WAIT discards the pending store
        @(negedge clk);
        req_valid0 = 1'b1;
        req_we     = 1'b1;
        req_byte   = 1'b0;
        req_addr   = 32'h20;
        req_wdata  = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        check("t3_wait_busy", {31'd0, busy0}, 32'd1);
        rst = 1'b1;
        #1;
        check("t3_rst_busy", {31'd0, busy0}, 32'd0);
        check("t3_rst_rdata", rdata0, 32'd0);
        req_valid0 = 1'b0;
        model_last = 32'd0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | ack0;
        end
        check("t3_no_ack", {31'd0, seen}, 32'd0);
        run_req("t3_lw", 1'b0, 1'b0, 32'h20, 32'd0);
        check("t3_discard", rdata0, 32'd0);

        // Back-to-back with req_valid held high
        for (int k = 0; k < 4; k++) model_access(1'b0, 1'b0, 32'h10, 32'd0);
        @(negedge clk);
        req_valid0 = 1'b1;
        req_we     = 1'b0;
        req_byte   = 1'b0;
        req_addr   = 32'h10;
        nacks = 0;
        for (int i = 0; i < 4 * (LAT + 2); i++) begin
            @(posedge clk);
            @(negedge clk);
            p = i % (LAT + 2);
            check("t4_ack", {31'd0, ack0}, {31'd0, p == LAT});
            check("t4_busy", {31'd0, busy0}, {31'd0, p != LAT + 1});
            if (ack0 && exp_q.size() > 0) begin
                nacks++;
                e = exp_q.pop_front();
                check("t4_rdata", rdata0, e[31:0]);
            end
            if (i == 4 * (LAT + 2) - 1) req_valid0 = 1'b0;
        end
        check("t4_nacks", nacks, 4);
        exp_q.delete();

        // Out-of-range / wrapping addresses
        run_req("t5_lw_hi", 1'b0, 1'b0, 32'h0000_1002, 32'd0);
        run_req("t5_sw_hi", 1'b1, 1'b0, 32'h0001_0000, 32'hA5A5_0F0F);
        run_req("t5_lw0", 1'b0, 1'b0, 32'h0, 32'd0);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 5) == 0) a = a | 32'h0001_0000;
            run_req("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
        end

        // LATENCY=1 instance
        run_l1("t6_lw0", 1'b0, 32'h0, 32'd0, 32'd0);
        run_l1("t6_sw", 1'b1, 32'h8, 32'hCAFE_F00D, 32'd0);
        run_l1("t6_lw8", 1'b0, 32'h8, 32'd0, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
